// File: rtl/rvlab_mmcm_drp_model.sv
// Behavioural stand-in for an MMCM DRP port and its lock output.
// Handles one DRP access at a time with a fixed response latency, plus a reset-to-lock counter.
module rvlab_mmcm_drp_model #(
  parameter int unsigned RDY_LATENCY = 4,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        drp_en_i,
  input  logic        drp_we_i,
  input  logic [6:0]  drp_adr_i,
  input  logic [15:0] drp_di_i,
  output logic        drp_rdy_o,
  output logic [15:0] drp_do_o,
  input  logic        mmcm_rst_i,
  output logic        locked_o,
  output logic [1:0]  err_o
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  typedef struct packed {
    logic        we;
    logic [6:0]  adr;
    logic [15:0] di;
  } drp_req_t;

  localparam logic [3:0] LAT_LOAD = 4'(RDY_LATENCY - 1);
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  drp_req_t    req_q, req_d;
  logic [15:0] mem_q [128];
  logic [7:0]  lock_cnt_q;
  logic [1:0]  err_q;
  logic        accept, resp;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    accept  = 1'b0;
    resp    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (drp_en_i) begin
          accept  = 1'b1;
          req_d   = '{we: drp_we_i, adr: drp_adr_i, di: drp_di_i};
          cnt_d   = LAT_LOAD;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          resp    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Writes land on the edge that closes the response cycle, so a read in that cycle sees old data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 128; i++) mem_q[i] <= '0;
    end else if (resp && req_q.we) begin
      mem_q[req_q.adr] <= req_q.di;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | {accept & drp_we_i & ~mmcm_rst_i,
                        (state_q == S_BUSY) & drp_en_i};
    end
  end

  // Saturating count of consecutive cycles with the MMCM out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_cnt_q <= '0;
    end else if (mmcm_rst_i) begin
      lock_cnt_q <= '0;
    end else if (lock_cnt_q != LOCK_MAX) begin
      lock_cnt_q <= lock_cnt_q + 8'd1;
    end
  end

  assign drp_rdy_o = resp;
  assign drp_do_o  = (resp && !req_q.we) ? mem_q[req_q.adr] : 16'h0000;
  assign locked_o  = !mmcm_rst_i && (lock_cnt_q == LOCK_MAX);
  assign err_o     = err_q;

endmodule

// File: tb/tb_rvlab_mmcm_drp_model.sv
// Bench for rvlab_mmcm_drp_model: one instance at latency 4, one at latency 1, shared reset/lock inputs.
// A cycle-numbered reference model predicts every output; directed tables and sequences pin the corner cases.
module tb_rvlab_mmcm_drp_model;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;
  localparam int LOCK = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmcm_rst;
  logic        drp_en  [2];
  logic        drp_we  [2];
  logic [6:0]  drp_adr [2];
  logic [15:0] drp_di  [2];
  logic        drp_rdy [2];
  logic [15:0] drp_do  [2];
  logic        locked  [2];
  logic [1:0]  err     [2];

  always #5 clk = ~clk;

  rvlab_mmcm_drp_model #(.RDY_LATENCY(LAT0), .LOCK_CYCLES(LOCK)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .drp_en_i(drp_en[0]), .drp_we_i(drp_we[0]), .drp_adr_i(drp_adr[0]), .drp_di_i(drp_di[0]),
    .drp_rdy_o(drp_rdy[0]), .drp_do_o(drp_do[0]),
    .mmcm_rst_i(mmcm_rst), .locked_o(locked[0]), .err_o(err[0])
  );

  rvlab_mmcm_drp_model #(.RDY_LATENCY(LAT1), .LOCK_CYCLES(LOCK)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .drp_en_i(drp_en[1]), .drp_we_i(drp_we[1]), .drp_adr_i(drp_adr[1]), .drp_di_i(drp_di[1]),
    .drp_rdy_o(drp_rdy[1]), .drp_do_o(drp_do[1]),
    .mmcm_rst_i(mmcm_rst), .locked_o(locked[1]), .err_o(err[1])
  );

  // Reference model: a request accepted at cycle N is due at cycle N+latency.
  logic [15:0] m_mem [2][128];
  bit          m_busy [2];
  int          m_due  [2];
  logic        m_we   [2];
  logic [6:0]  m_adr  [2];
  logic [15:0] m_di   [2];
  logic [1:0]  m_err  [2];
  int          low_run;
  int          cyc;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        en;
    logic        we;
    logic [6:0]  adr;
    logic [15:0] di;
    logic        rdy;
    logic [15:0] dout;
    logic [1:0]  err;
  } vec_t;

  vec_t        tbl [42];
  logic [15:0] wdata [128];

  task automatic chk(string name, int d, logic [15:0] act, logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  function automatic int lat(int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 128; a++) m_mem[d][a] = 16'h0000;
      m_busy[d] = 1'b0;
      m_due[d]  = 0;
      m_err[d]  = 2'b00;
      drp_en[d] = 1'b0;
    end
    low_run = 0;
  endtask

  task automatic req(int d, logic we, logic [6:0] adr, logic [15:0] di);
    drp_en[d]  = 1'b1;
    drp_we[d]  = we;
    drp_adr[d] = adr;
    drp_di[d]  = di;
  endtask

  task automatic sample();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic        rdy_e;
      logic [15:0] do_e;
      rdy_e = m_busy[d] && (cyc == m_due[d]);
      do_e  = (rdy_e && !m_we[d]) ? m_mem[d][m_adr[d]] : 16'h0000;
      chk("rdy", d, 16'(drp_rdy[d]), 16'(rdy_e));
      chk("do", d, drp_do[d], do_e);
      chk("err", d, 16'(err[d]), 16'(m_err[d]));
      chk("locked", d, 16'(locked[d]), 16'(!mmcm_rst && low_run >= LOCK));
    end
  endtask

  task automatic advance();
    for (int d = 0; d < 2; d++) begin
      bit rdy_e;
      rdy_e = m_busy[d] && (cyc == m_due[d]);
      if (drp_en[d]) begin
        if (m_busy[d]) begin
          m_err[d][0] = 1'b1;
        end else begin
          m_busy[d] = 1'b1;
          m_due[d]  = cyc + lat(d);
          m_we[d]   = drp_we[d];
          m_adr[d]  = drp_adr[d];
          m_di[d]   = drp_di[d];
          if (drp_we[d] && !mmcm_rst) m_err[d][1] = 1'b1;
        end
      end
      if (rdy_e) begin
        if (m_we[d]) m_mem[d][m_adr[d]] = m_di[d];
        m_busy[d] = 1'b0;
      end
    end
    low_run = mmcm_rst ? 0 : low_run + 1;
    cyc++;
    @(posedge clk);
    #1;
    drp_en[0] = 1'b0;
    drp_en[1] = 1'b0;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  // Asserts rst_i immediately (mid-cycle when called off-edge) and checks outputs react without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", d, 16'(drp_rdy[d]), 16'h0);
      chk("rst_do", d, drp_do[d], 16'h0);
      chk("rst_locked", d, 16'(locked[d]), 16'h0);
      chk("rst_err", d, 16'(err[d]), 16'h0);
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mmcm_rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      drp_en[d] = 1'b0; drp_we[d] = 1'b0; drp_adr[d] = '0; drp_di[d] = '0;
    end
    cyc = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed table on the latency-4 instance: write/readback, then requests while busy.
    for (int i = 0; i < 42; i++)
      tbl[i] = '{en: 1'b0, we: 1'b0, adr: 7'h00, di: 16'h0000, rdy: 1'b0, dout: 16'h0000,
                 err: (i >= 33) ? 2'b01 : 2'b00};
    tbl[10] = '{en: 1'b1, we: 1'b1, adr: 7'h08, di: 16'hA5C3, rdy: 1'b0, dout: 16'h0000, err: 2'b00};
    tbl[14].rdy = 1'b1;
    tbl[15] = '{en: 1'b1, we: 1'b0, adr: 7'h08, di: 16'h0000, rdy: 1'b0, dout: 16'h0000, err: 2'b00};
    tbl[19].rdy = 1'b1; tbl[19].dout = 16'hA5C3;
    tbl[30] = '{en: 1'b1, we: 1'b0, adr: 7'h08, di: 16'h0000, rdy: 1'b0, dout: 16'h0000, err: 2'b00};
    tbl[32] = '{en: 1'b1, we: 1'b1, adr: 7'h09, di: 16'h1234, rdy: 1'b0, dout: 16'h0000, err: 2'b00};
    tbl[34] = '{en: 1'b1, we: 1'b1, adr: 7'h09, di: 16'h1234, rdy: 1'b1, dout: 16'hA5C3, err: 2'b01};
    tbl[36] = '{en: 1'b1, we: 1'b0, adr: 7'h09, di: 16'h0000, rdy: 1'b0, dout: 16'h0000, err: 2'b01};
    tbl[40].rdy = 1'b1;
    for (int i = 0; i < 42; i++) begin
      if (tbl[i].en) req(0, tbl[i].we, tbl[i].adr, tbl[i].di);
      sample();
      chk("tbl_rdy", 0, 16'(drp_rdy[0]), 16'(tbl[i].rdy));
      chk("tbl_do", 0, drp_do[0], tbl[i].dout);
      chk("tbl_err", 0, 16'(err[0]), 16'(tbl[i].err));
      advance();
    end

    // Lock timing, with a write issued while the MMCM is out of reset.
    do_reset();
    for (int c = 0; c <= 70; c++) begin
      mmcm_rst = (c <= 20) || (c == 50);
      if (c == 25) req(0, 1'b1, 7'h4F, 16'h5A3C);
      if (c == 31) req(0, 1'b0, 7'h4F, 16'h0000);
      sample();
      if (c == 36 || c == 50 || c == 66) chk("lock_lo", 0, 16'(locked[0]), 16'h0);
      if (c == 37 || c == 49 || c == 67) chk("lock_hi", 0, 16'(locked[0]), 16'h1);
      if (c == 35) chk("wr_unlocked_rd", 0, drp_do[0], 16'h5A3C);
      if (c == 35 || c == 70) chk("wr_unlocked_err", 0, 16'(err[0]), 16'h2);
      advance();
    end

    // Latency-1 back-to-back sweep over every address.
    mmcm_rst = 1'b1;
    do_reset();
    for (int a = 0; a < 128; a++) begin
      wdata[a] = 16'($urandom);
      req(1, 1'b1, 7'(a), wdata[a]);
      tick();
      sample();
      chk("b2b_wr_rdy", 1, 16'(drp_rdy[1]), 16'h1);
      advance();
    end
    for (int a = 0; a < 128; a++) begin
      req(1, 1'b0, 7'(a), 16'h0000);
      tick();
      sample();
      chk("b2b_rd", 1, drp_do[1], wdata[a]);
      advance();
    end
    chk("b2b_err", 1, 16'(err[1]), 16'h0);

    // Randomized traffic with occasional MMCM reset toggles.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) mmcm_rst = ~mmcm_rst;
      for (int d = 0; d < 2; d++)
        if ($urandom_range(0, 3) == 0)
          req(d, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 16'($urandom));
      tick();
    end

    // Reset while requests are in flight: no completion, no write.
    mmcm_rst = 1'b0;
    repeat (20) tick();
    req(0, 1'b1, 7'h21, 16'hBEEF);
    req(1, 1'b1, 7'h22, 16'hCAFE);
    tick();
    #2;
    do_reset();
    req(0, 1'b0, 7'h21, 16'h0000);
    req(1, 1'b0, 7'h22, 16'h0000);
    for (int c = 0; c < 6; c++) begin
      sample();
      if (c == 1) chk("abort_rd", 1, drp_do[1], 16'h0000);
      if (c == 4) begin
        chk("abort_rd_rdy", 0, 16'(drp_rdy[0]), 16'h1);
        chk("abort_rd", 0, drp_do[0], 16'h0000);
      end
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
